// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream engine.
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Smallest output buffer that sustains one word per cycle across the read latency.
  localparam int MIN_BUF_DEPTH = 3;

  localparam int BEAT_DATA_WIDTH = 4;

  typedef struct packed {
    logic                       last;
    logic [BEAT_DATA_WIDTH-1:0] data;
  } beat_t;

endpackage

// File: rtl/fifo_rd_stream_rd_out_buf.sv
// Small synchronous FIFO holding {last,data} beats between the FIFO read port and the stream.
module rd_out_buf
  import fifo_rd_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int DEPTH = 3,
  parameter int OW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [OW-1:0]    occ
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [OW-1:0]    occ_q, occ_d;
  logic             pop_ok, push_ok;

  always_comb begin
    pop_ok   = pop && (occ_q != '0);
    push_ok  = push && ((occ_q != OW'(DEPTH)) || pop_ok);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (push_ok && !pop_ok) begin
      occ_d = occ_q + OW'(1);
    end else if (pop_ok && !push_ok) begin
      occ_d = occ_q - OW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Head reads as zero when empty so the stream outputs are clean after a flush.
  assign head = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign occ  = occ_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side engine: issues FIFO reads for bursts or continuous drain and presents a valid/ready stream.
// Stream handshake: a beat transfers on a cycle with m_valid && m_ready; while m_valid && !m_ready, m_data/m_last hold.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int CNT_WIDTH  = 8,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  burst_len,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_r_data,
  output logic                  fifo_r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_cnt,
  output logic [1:0]            dbg_state
);

  localparam int OW = $clog2(BUF_DEPTH + 1);

  if (BUF_DEPTH < MIN_BUF_DEPTH) begin : g_depth_check
    $error("fifo_rd_stream: BUF_DEPTH below minimum");
  end

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] burst_len_q, burst_len_d;
  logic [CNT_WIDTH-1:0] issued_q, issued_d;
  logic [CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                 infl_q, infl_d;
  logic                 infl_last_q, infl_last_d;
  logic                 done_q, done_d;

  logic [OW-1:0]        occ;
  logic [DATA_WIDTH:0]  head;
  logic [CNT_WIDTH:0]   issued_nxt;
  logic                 burst_mode, room, can_issue, burst_hit, hs;

  // Read issue looks only at registered state, fifo_empty and stop; m_ready never reaches fifo_r_en.
  always_comb begin
    burst_mode = (burst_len_q != '0);
    room       = ({1'b0, occ} + (OW + 1)'(infl_q)) < (OW + 1)'(BUF_DEPTH);
    can_issue  = burst_mode ? (issued_q < burst_len_q) : !stop;
    fifo_r_en  = !r_rst && (state_q == RUN) && !fifo_empty && room && can_issue;
    // One extra bit so a full-range burst length compares before the counter wraps.
    issued_nxt = {1'b0, issued_q} + (CNT_WIDTH + 1)'(fifo_r_en);
    burst_hit  = burst_mode && (issued_nxt == {1'b0, burst_len_q});
    hs         = m_valid && m_ready;
  end

  always_comb begin
    state_d     = state_q;
    burst_len_d = burst_len_q;
    issued_d    = issued_nxt[CNT_WIDTH-1:0];
    rd_cnt_d    = rd_cnt_q + CNT_WIDTH'(hs);
    infl_d      = fifo_r_en;
    infl_last_d = fifo_r_en && burst_hit;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          burst_len_d = burst_len;
          issued_d    = '0;
          rd_cnt_d    = '0;
        end
      end
      RUN: begin
        if (burst_hit || (!burst_mode && stop)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((occ == '0) && !infl_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q     <= IDLE;
      burst_len_q <= '0;
      issued_q    <= '0;
      rd_cnt_q    <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_len_q <= burst_len_d;
      issued_q    <= issued_d;
      rd_cnt_q    <= rd_cnt_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      done_q      <= done_d;
    end
  end

  rd_out_buf #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (BUF_DEPTH),
    .OW    (OW)
  ) u_buf (
    .clk       (r_clk),
    .rst       (r_rst),
    .push      (infl_q),
    .push_data ({infl_last_q, fifo_r_data}),
    .pop       (hs),
    .head      (head),
    .occ       (occ)
  );

  assign m_valid   = (occ != '0);
  assign m_data    = head[DATA_WIDTH-1:0];
  assign m_last    = head[DATA_WIDTH];
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign rd_cnt    = rd_cnt_q;
  assign dbg_state = state_q;

endmodule
